// File: rtl/efx_uart_rx_monitor.sv
// 8N1 UART receiver with a show-ahead byte FIFO and valid/ready output.
// Framing errors pulse for one cycle; FIFO overflow is sticky until reset.
module efx_uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          io_axiClk,
    input  logic                          io_reset,
    input  logic                          io_rxd,
    output logic [7:0]                    io_data,
    output logic                          io_valid,
    input  logic                          io_ready,
    output logic [$clog2(FIFO_DEPTH):0]   io_count,
    output logic                          io_frameError,
    output logic                          io_overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]   OCC_ONE = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state_q;
    logic [1:0]    sync_q;
    logic          rxs;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          ferr_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          ovf_q;

    logic          push;
    logic          pop;
    logic          wr_ok;

    assign rxs = sync_q[1];

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], io_rxd};
        end
    end

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (!rxs) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        state_q <= rxs ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxs;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BRK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                // Held-low line must return high before a new start is armed
                BRK: begin
                    if (rxs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The byte enters the FIFO on the stop-sample edge itself
    assign push  = (state_q == STOP) && (cnt_q == FULL_M1) && rxs;
    assign pop   = (count_q != '0) && io_ready;
    assign wr_ok = push && ((count_q < DEPTH_C) || pop);

    always_comb begin
        count_d = count_q;
        unique case ({wr_ok, pop})
            2'b10:   count_d = count_q + OCC_ONE;
            2'b01:   count_d = count_q - OCC_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_ok) begin
                wr_q <= wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
            if (push && !wr_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge io_axiClk) begin
        if (!io_reset && wr_ok) begin
            mem_q[wr_q] <= shift_q;
        end
    end

    assign io_valid      = (count_q != '0);
    assign io_data       = io_valid ? mem_q[rd_q] : 8'h00;
    assign io_count      = count_q;
    assign io_frameError = ferr_q;
    assign io_overflow   = ovf_q;

endmodule

// File: tb/tb_efx_uart_rx_monitor.sv
// Bench for efx_uart_rx_monitor: fixed vectors, corner sequences and
// randomized frame batches against a queue-based reference model.
module tb_efx_uart_rx_monitor;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       ferr;
    logic       ovf;

    int errors = 0;
    int checks = 0;
    int ferr_seen = 0;

    efx_uart_rx_monitor #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .io_axiClk    (clk),
        .io_reset     (rst),
        .io_rxd       (rxd),
        .io_data      (data),
        .io_valid     (valid),
        .io_ready     (ready),
        .io_count     (count),
        .io_frameError(ferr),
        .io_overflow  (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ferr) ferr_seen <= ferr_seen + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rxd = 1'b1;
        ready = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_cyc(CPB);
        end
        rxd = stop;
        wait_cyc(CPB);
    endtask

    task automatic pop_one();
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int f0;
        logic [7:0] partial;
        logic [7:0] q[$];
        logic exp_ovf;
        int exp_ferr;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};

        do_reset();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ferr", 32'(ferr), 0);
        chk("rst_ovf", 32'(ovf), 0);

        // Exact-latency single frames with ready held high
        for (int v = 0; v < 6; v++) begin
            do_reset();
            ready = 1'b1;
            fork
                send_frame(vecs[v].data, vecs[v].stop);
                begin
                    wait_cyc(78);
                    chk("vec_pre_valid", 32'(valid), 0);
                    chk("vec_pre_ferr", 32'(ferr), 0);
                    wait_cyc(1);
                    chk("vec_valid", 32'(valid), 32'(vecs[v].exp_valid));
                    chk("vec_data", 32'(data), 32'(vecs[v].exp_data));
                    chk("vec_ferr", 32'(ferr), 32'(vecs[v].exp_ferr));
                    chk("vec_ovf", 32'(ovf), 0);
                    wait_cyc(1);
                    chk("vec_post_valid", 32'(valid), 0);
                    chk("vec_post_ferr", 32'(ferr), 0);
                end
            join
            rxd = 1'b1;
            wait_cyc(2 * CPB);
        end

        // Back-to-back frames, consumer stalled
        do_reset();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cyc(4);
        chk("b2b_count", 32'(count), 2);
        chk("b2b_head0", 32'(data), 32'h00);
        pop_one();
        chk("b2b_head1", 32'(data), 32'hFF);
        chk("b2b_count1", 32'(count), 1);
        pop_one();
        chk("b2b_empty", 32'(valid), 0);

        // Framing error followed by a long break
        do_reset();
        f0 = ferr_seen;
        send_frame(8'h3C, 1'b0);
        wait_cyc(20 * CPB);
        chk("brk_count", 32'(count), 0);
        rxd = 1'b1;
        wait_cyc(2 * CPB);
        chk("brk_pulses", 32'(ferr_seen - f0), 1);
        chk("brk_empty", 32'(valid), 0);
        send_frame(8'h11, 1'b1);
        wait_cyc(4);
        chk("brk_next_count", 32'(count), 1);
        chk("brk_next_data", 32'(data), 32'h11);
        pop_one();

        // Two-cycle glitch on the idle line
        do_reset();
        f0 = ferr_seen;
        rxd = 1'b0;
        wait_cyc(2);
        rxd = 1'b1;
        wait_cyc(4 * CPB);
        chk("gl_valid", 32'(valid), 0);
        chk("gl_count", 32'(count), 0);
        chk("gl_ferr", 32'(ferr_seen - f0), 0);
        chk("gl_ovf", 32'(ovf), 0);

        // Overflow on a full FIFO, then ordered drain
        do_reset();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        wait_cyc(2);
        chk("of_pre_ovf", 32'(ovf), 0);
        send_frame(8'h05, 1'b1);
        wait_cyc(4);
        chk("of_count", 32'(count), 4);
        chk("of_ovf", 32'(ovf), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("of_drain", 32'(data), 32'(i));
            pop_one();
        end
        chk("of_empty", 32'(valid), 0);
        chk("of_sticky", 32'(ovf), 1);

        // Reset during data bit 4 of 0x5A with a byte already queued
        do_reset();
        send_frame(8'h42, 1'b1);
        wait_cyc(4);
        chk("mr_pre_count", 32'(count), 1);
        partial = 8'h5A;
        rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = partial[i];
            wait_cyc(CPB);
        end
        rxd = partial[4];
        wait_cyc(4);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        rxd = 1'b1;
        chk("mr_valid", 32'(valid), 0);
        chk("mr_data", 32'(data), 0);
        chk("mr_count", 32'(count), 0);
        chk("mr_ferr", 32'(ferr), 0);
        chk("mr_ovf", 32'(ovf), 0);
        wait_cyc(3 * CPB);
        chk("mr_idle_count", 32'(count), 0);
        send_frame(8'h77, 1'b1);
        wait_cyc(4);
        chk("mr_next_count", 32'(count), 1);
        chk("mr_next_data", 32'(data), 32'h77);
        pop_one();
        chk("mr_empty", 32'(valid), 0);

        // Randomized batches against a queue model of the receiver
        do_reset();
        exp_ovf = 1'b0;
        for (int b = 0; b < 8; b++) begin
            int n;
            f0 = ferr_seen;
            exp_ferr = 0;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                logic [7:0] d;
                logic good;
                d = 8'($urandom);
                good = ($urandom_range(0, 9) != 0);
                send_frame(d, good);
                if (good) begin
                    if (q.size() < DEPTH) q.push_back(d);
                    else exp_ovf = 1'b1;
                    wait_cyc(CPB * $urandom_range(0, 2));
                end else begin
                    exp_ferr++;
                    wait_cyc(CPB * $urandom_range(1, 3));
                    rxd = 1'b1;
                    wait_cyc(CPB);
                end
            end
            wait_cyc(4);
            chk("rnd_count", 32'(count), 32'(q.size()));
            chk("rnd_ovf", 32'(ovf), 32'(exp_ovf));
            chk("rnd_ferr", 32'(ferr_seen - f0), 32'(exp_ferr));
            while (q.size() > 0) begin
                logic [7:0] e;
                e = q.pop_front();
                chk("rnd_valid", 32'(valid), 1);
                chk("rnd_data", 32'(data), 32'(e));
                pop_one();
            end
            chk("rnd_empty", 32'(valid), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/efx_uart_rx_monitor.md
# efx_uart_rx_monitor

Serial-to-byte receiver consuming the SoC's `io_uartA_txd` line, 8N1 framing, LSB first. It delivers decoded bytes through a small show-ahead FIFO with a valid/ready handshake. It sits directly downstream of the `EFX_Riscv` UART transmitter, in simulation benches and in on-chip debug capture. Framing errors and FIFO overflow are reported as status.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: `io_axiClk` cycles per UART bit (50 MHz / 115200). Must be ≥ 4 and even.
- `FIFO_DEPTH`, 4: byte FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- `io_axiClk`  in  1  system clock. Every register is clocked on its rising edge.
- `io_reset`  in  1  reset. One clock; reset is synchronous and active-high.
- `io_rxd`  in  1  serial input, idle high. Connects to SoC `io_uartA_txd`.
- `io_data`  out  8  FIFO head byte. Meaningful only while `io_valid`=1.
- `io_valid`  out  1  FIFO non-empty.
- `io_ready`  in  1  consumer accepts the head byte when `io_valid & io_ready`.
- `io_count`  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `io_frameError`  out  1  one-cycle pulse when a stop bit is sampled low.
- `io_overflow`  out  1  sticky flag, set when a good byte arrives while the FIFO is full.

## Operation
- Input path: 2-flop synchronizer on `io_rxd`, both flops reset to 1. The FSM sees only the synchronized value `rxs`.
- Bit counter: 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT). Bit index: 0..7.
- FSM states:
  - IDLE: `rxs`=0 → START, counter cleared.
  - START: at count CLKS_PER_BIT/2-1, sample `rxs`. If 0 → DATA, counter cleared. If 1, treat as a glitch → IDLE with no flags.
  - DATA: at count CLKS_PER_BIT-1, shift `rxs` into bit[index] (LSB first) and clear the counter. After index 7 → STOP.
  - STOP: at count CLKS_PER_BIT-1, sample `rxs`.
    - If 1: push the byte, → IDLE.
    - If 0: pulse `io_frameError`, discard the byte, → BREAK.
  - BREAK: stay until `rxs`=1, then → IDLE. This prevents a held-low line from re-triggering as a start bit.
- FIFO push/pop:
  - A push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped, the FIFO is unchanged, and `io_overflow` is set.
  - Pop on `io_valid & io_ready`. With `io_valid`=0, `io_ready` is ignored.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers have width clog2(FIFO_DEPTH) and wrap naturally.
- Show-ahead output: `io_data` = mem[rdPtr] whenever the FIFO is non-empty.
- Reset takes priority over all activity, including mid-frame. It returns the FSM to IDLE, empties the FIFO and clears all flags. A partially received byte is lost.
- Reset values: `io_data`=8'h00, `io_valid`=0, `io_count`=0, `io_frameError`=0, `io_overflow`=0.

## Timing
- Let cycle 0 be the first `io_axiClk` edge that samples `io_rxd`=0.
  - `rxs` goes low after cycle 2.
  - The stop sample occurs at cycle 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
  - `io_valid` (or `io_frameError`) is high from the following cycle.
  - Example: CLKS_PER_BIT=8 gives `io_valid` at cycle 79.
- The FSM reaches IDLE in the stop-sample cycle. A start edge arriving half a bit later is captured, so back-to-back frames need no extra idle time.
- Pop: the head advances and `io_count` decrements on the edge where `io_valid & io_ready`. The new head appears in the next cycle.
- `io_frameError` is exactly 1 cycle wide.
- `io_overflow` rises the cycle after the dropped push and stays high until `io_reset`.

## Test plan
- Single byte, CLKS_PER_BIT=8, `io_ready`=1: send 0xA5 → `io_valid`=1 at cycle 79 with `io_data`=8'hA5, for one cycle only. `io_frameError`=0, `io_overflow`=0.
- Back-to-back frames: send 0x00 then 0xFF with no idle gap, `io_ready`=0 → `io_count`=2, head 8'h00. After one pop, head is 8'hFF and `io_count`=1.
- Framing error: send 0x3C with stop bit 0, then hold low for 20 bits, then release → one `io_frameError` pulse, FIFO stays empty, no byte decoded during the low period. A following 0x11 is received correctly.
- Glitch: `io_rxd` low for 2 cycles (CLKS_PER_BIT=8) → no state change, no flags, FIFO empty.
- Overflow, FIFO_DEPTH=4, `io_ready`=0: send 0x01..0x05 → `io_count`=4 holding 0x01..0x04, `io_overflow`=1 after frame 5. Draining yields 01,02,03,04 in order.
- Reset mid-frame: assert `io_reset` for 1 cycle during DATA bit 4 of 0x5A → all outputs return to reset values. The next full frame 0x77 is received correctly and nothing from 0x5A appears.
